mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencer for the fixed-point MAC datapath (22-bit Q6.16 multiply-accumulate core with synchronous clear and enable). For one dense layer it clears the accumulator, streams WIDTH pixel/weight address pairs to the synchronous pixel and weight memories, and asserts the MAC enable aligned to the returned data. It then captures each neuron's sum and hands it downstream over a valid/ready port, repeating for all NEURONS outputs. It sits between the layer-level top (start/done) and the MAC core plus its two memories.

## Interface
- WGHT_INT, 6, integer bits of the Q format (sign included)
- WGHT_FRC, 16, fractional bits
- WIDTH, 784, inputs per neuron (≥2)
- NEURONS, 10, neurons per layer (≥1)
- DW = WGHT_INT+WGHT_FRC; PAW = $clog2(WIDTH); WAW = $clog2(WIDTH*NEURONS); NIW = $clog2(NEURONS) (min 1), derived
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- rd_en  out  1  read strobe to pixel and weight memories (1-cycle read latency)
- pix_addr  out  PAW  pixel index k
- wgt_addr  out  WAW  weight index n*WIDTH+k
- mac_clr  out  1  drives MAC core reset
- mac_en  out  1  drives MAC core en
- mac_out  in  DW  MAC accumulator value
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  DW  neuron sum, two's complement Q6.16
- res_idx  out  NIW  neuron index n of res_data

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, CAPTURE, OUT.
- IDLE: start=1 → CLEAR, n=0, wgt_addr base=0. start=0 → stay.
- CLEAR (1 cycle): mac_clr=1; k=0 → FEED.
- FEED (WIDTH cycles): rd_en=1, pix_addr=k, wgt_addr=base+k, k increments; on k=WIDTH-1 → DRAIN.
- mac_en is rd_en registered one cycle (matches memory latency); it is never asserted in CLEAR.
- DRAIN (1 cycle): rd_en=0, mac_en=1 for the final element → CAPTURE.
- CAPTURE (1 cycle): mac_en=0; res_data←mac_out, res_idx←n → OUT.
- OUT: res_valid=1; hold res_data/res_idx stable until res_ready=1. On handshake: if n=NEURONS-1 → IDLE with done pulse; else n+1, base+=WIDTH → CLEAR.
- Weight address generated by incrementing base, no multiplier.
- No arithmetic on data other than optional ReLU; no saturation (MAC core wraps mod 2^DW).
- start asserted while busy: ignored.

## Timing
- Reset values: busy=0, done=0, rd_en=0, pix_addr=0, wgt_addr=0, mac_clr=1 during reset, 0 after; mac_en=0, res_valid=0, res_data=0, res_idx=0; state IDLE.
- Reset mid-operation: immediate return to IDLE next edge, outputs to reset values; no done pulse.
- Per neuron: CLEAR 1 + FEED WIDTH + DRAIN 1 + CAPTURE 1 + OUT ≥1 = WIDTH+4 cycles minimum.
- Layer with res_ready tied high: NEURONS*(WIDTH+4) cycles from start sample to done pulse. done is asserted in the first IDLE cycle.
- busy rises the cycle after start is sampled and falls with done.
- mac_en high for exactly WIDTH cycles per neuron: the last FEED-1 cycles plus DRAIN.
- res_valid stays high with res_ready low for any number of cycles; the MAC core is idle (mac_en=0) while waiting.
- A new start is accepted in the same cycle done is high (state is IDLE).

## Configuration
- MAC_SEQ_RELU_EN defined: in CAPTURE, res_data←0 if mac_out[DW-1]=1, else mac_out.
- Undefined: res_data←mac_out unmodified (signed).

## Test plan
- WIDTH=4, NEURONS=2, pixels all 1.0 (0x10000), weights n0={1.0,2.0,3.0,4.0}, n1={0.5 ×4}, ready high → res_data 0x0A0000 idx0 at cycle 8, 0x020000 idx1 at cycle 16, done at 17.
- Backpressure: res_ready low for 5 cycles in OUT → res_valid and res_data held, mac_en=0, done delayed by exactly 5 cycles.
- Negative sum (weights all -1.0, pixels 1.0, WIDTH=4) → 0x3C0000 (-4.0) without macro; 0 with MAC_SEQ_RELU_EN.
- Reset asserted in FEED at k=2 → next cycle IDLE, all outputs at reset values; a subsequent start gives correct sums (accumulator cleared).
- start held high through a whole layer → exactly one layer run per IDLE sample; start pulsed while busy → no effect.
- Address check WIDTH=784, NEURONS=10: wgt_addr spans 0..7839 contiguously, pix_addr wraps 0..783 per neuron, mac_en count = 784 per neuron.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Dense-layer sequencer for the Q6.16 MAC datapath: clears, feeds, drains and
// captures one neuron at a time, then hands results out over valid/ready.
// Optional: define MAC_SEQ_RELU_EN to clamp negative sums to zero on capture.
module mac_seq_ctrl #(
  parameter int WGHT_INT = 6,
  parameter int WGHT_FRC = 16,
  parameter int WIDTH    = 784,
  parameter int NEURONS  = 10,
  localparam int DW  = WGHT_INT + WGHT_FRC,
  localparam int PAW = $clog2(WIDTH),
  localparam int WAW = $clog2(WIDTH * NEURONS),
  localparam int NIW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [PAW-1:0] pix_addr,
  output logic [WAW-1:0] wgt_addr,
  output logic           mac_clr,
  output logic           mac_en,
  input  logic [DW-1:0]  mac_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic [NIW-1:0] res_idx
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, CAPTURE, OUT
  } state_t;

  localparam logic [PAW-1:0] K_LAST = PAW'(WIDTH - 1);
  localparam logic [NIW-1:0] N_LAST = NIW'(NEURONS - 1);

  state_t         state, state_nx;
  logic [PAW-1:0] k_q;
  logic [WAW-1:0] wa_q;
  logic [NIW-1:0] n_q;
  logic [DW-1:0]  cap_val;
  logic           handshake;

`ifdef MAC_SEQ_RELU_EN
  assign cap_val = mac_out[DW-1] ? '0 : mac_out;
`else
  assign cap_val = mac_out;
`endif

  assign handshake = (state == OUT) && res_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = FEED;
      FEED:    if (k_q == K_LAST) state_nx = DRAIN;
      DRAIN:   state_nx = CAPTURE;
      CAPTURE: state_nx = OUT;
      OUT:     if (res_ready) state_nx = (n_q == N_LAST) ? IDLE : CLEAR;
      default: state_nx = IDLE;
    endcase
  end

  // The weight address just keeps counting across neurons, so it always equals
  // n*WIDTH + k without any multiply or explicit base register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k_q      <= '0;
      wa_q     <= '0;
      n_q      <= '0;
      mac_en   <= 1'b0;
      done     <= 1'b0;
      res_data <= '0;
      res_idx  <= '0;
    end else begin
      state  <= state_nx;
      mac_en <= (state == FEED);
      done   <= handshake && (n_q == N_LAST);
      case (state)
        IDLE: begin
          if (start) begin
            n_q  <= '0;
            wa_q <= '0;
          end
        end
        CLEAR: k_q <= '0;
        FEED: begin
          k_q  <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
          wa_q <= wa_q + 1'b1;
        end
        CAPTURE: begin
          res_data <= cap_val;
          res_idx  <= n_q;
        end
        OUT: if (res_ready && (n_q != N_LAST)) n_q <= n_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign rd_en     = (state == FEED);
  assign pix_addr  = k_q;
  assign wgt_addr  = wa_q;
  assign mac_clr   = reset || (state == CLEAR);
  assign res_valid = (state == OUT);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: small 4x2 layer with memory + MAC core models and a
// result scoreboard, plus a full-size 784x10 instance for the address sweep.
module tb_mac_seq_ctrl;

  localparam int DW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance: WIDTH=4, NEURONS=2
  logic          reset, start, res_ready;
  logic          busy, done, rd_en, mac_clr, mac_en, res_valid;
  logic [1:0]    pix_addr;
  logic [2:0]    wgt_addr;
  logic [DW-1:0] mac_out, res_data;
  logic [0:0]    res_idx;

  mac_seq_ctrl #(.WGHT_INT(6), .WGHT_FRC(16), .WIDTH(4), .NEURONS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .pix_addr(pix_addr), .wgt_addr(wgt_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx)
  );

  // full-size instance for address / enable counting
  logic          start2;
  logic          busy2, done2, rd_en2, mac_clr2, mac_en2, res_valid2;
  logic [9:0]    pix_addr2;
  logic [12:0]   wgt_addr2;
  logic [DW-1:0] res_data2;
  logic [3:0]    res_idx2;

  mac_seq_ctrl #(.WGHT_INT(6), .WGHT_FRC(16), .WIDTH(784), .NEURONS(10)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .pix_addr(pix_addr2), .wgt_addr(wgt_addr2),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .mac_out(22'h0),
    .res_valid(res_valid2), .res_ready(1'b1), .res_data(res_data2),
    .res_idx(res_idx2)
  );

  // memories (1-cycle read latency) and MAC core model
  logic [DW-1:0] pix_mem [4];
  logic [DW-1:0] wgt_mem [8];
  logic [DW-1:0] pix_q, wgt_q, acc;
  logic signed [2*DW-1:0] prod;

  assign prod    = $signed(pix_q) * $signed(wgt_q);
  assign mac_out = acc;

  always @(posedge clk) begin
    if (rd_en) begin
      pix_q <= pix_mem[pix_addr];
      wgt_q <= wgt_mem[wgt_addr];
    end
    if (mac_clr)     acc <= '0;
    else if (mac_en) acc <= acc + prod[DW-1+16:16];
  end

  typedef struct {
    logic [DW-1:0]             pix;
    logic [1:0][3:0][DW-1:0]   w;
    logic [DW-1:0]             exp0;
    logic [DW-1:0]             exp1;
    int                        stall;
    int                        lat;
  } vec_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  vec_t vecs [4];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] v);
`ifdef MAC_SEQ_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic run(input int v, input bit hold);
    int   lat, ew, macc, waitc, nres, first_valid;
    bit   got_done;
    exp_t e;
    for (int k = 0; k < 4; k++) pix_mem[k] = vecs[v].pix;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 4; k++) wgt_mem[n*4+k] = vecs[v].w[n][k];
    e.idx = 0; e.data = model_out(vecs[v].exp0); sb.push_back(e);
    e.idx = 1; e.data = model_out(vecs[v].exp1); sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    lat = 0; ew = 0; macc = 0; waitc = 0; nres = 0; first_valid = -1; got_done = 1'b0;
    while (!got_done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!hold) start = (lat == 3);
      if (lat == 1) chk("busy_rise", busy, 1'b1);
      if (rd_en) begin
        chk("pix_addr", pix_addr, 64'(ew % 4));
        chk("wgt_addr", wgt_addr, 64'(ew));
        ew++;
      end
      if (mac_en) macc++;
      if (res_valid) begin
        if (first_valid < 0) begin
          first_valid = lat;
          chk("first_valid_cycle", 64'(lat), 64'd8);
        end
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
          res_ready = 1'b1;
        end else if (waitc < vecs[v].stall) begin
          res_ready = 1'b0;
          waitc++;
          chk("stall_mac_en", mac_en, 1'b0);
          chk("stall_res_data", res_data, sb[0].data);
        end else begin
          res_ready = 1'b1;
          e = sb.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_idx", 64'(res_idx), 64'(e.idx));
          waitc = 0;
          nres++;
        end
      end else begin
        res_ready = 1'b1;
      end
      if (done) got_done = 1'b1;
    end
    chk("done_seen", got_done, 1'b1);
    chk("done_latency", 64'(lat), 64'(vecs[v].lat));
    chk("mac_en_count", 64'(macc), 64'd8);
    chk("rd_count", 64'(ew), 64'd8);
    chk("result_count", 64'(nres), 64'd2);
    if (!hold) begin
      @(negedge clk);
      chk("idle_after_done", {busy, done}, 2'b00);
    end
  endtask

  initial begin
    int  lat, ew, addr_err, nmac, nres;
    bit  got;

    // 1.0, 2.0, 3.0, 4.0 in Q6.16 are 0x10000 steps; -1.0 = 0x3F0000
    vecs[0].pix = 22'h010000;
    vecs[0].w[0] = {22'h040000, 22'h030000, 22'h020000, 22'h010000};
    vecs[0].w[1] = {22'h008000, 22'h008000, 22'h008000, 22'h008000};
    vecs[0].exp0 = 22'h0A0000; vecs[0].exp1 = 22'h020000;
    vecs[0].stall = 0; vecs[0].lat = 17;

    vecs[1].pix = 22'h020000;
    vecs[1].w[0] = {22'h004000, 22'h000000, 22'h3F8000, 22'h018000};
    vecs[1].w[1] = {22'h030000, 22'h030000, 22'h030000, 22'h030000};
    vecs[1].exp0 = 22'h028000; vecs[1].exp1 = 22'h180000;
    vecs[1].stall = 5; vecs[1].lat = 27;

    vecs[2].pix = 22'h010000;
    vecs[2].w[0] = {22'h3F0000, 22'h3F0000, 22'h3F0000, 22'h3F0000};
    vecs[2].w[1] = {22'h004000, 22'h004000, 22'h004000, 22'h004000};
    vecs[2].exp0 = 22'h3C0000; vecs[2].exp1 = 22'h010000;
    vecs[2].stall = 0; vecs[2].lat = 17;

    // 64.0 wraps to zero modulo 2^22
    vecs[3].pix = 22'h040000;
    vecs[3].w[0] = {22'h040000, 22'h040000, 22'h040000, 22'h040000};
    vecs[3].w[1] = {22'h000000, 22'h000000, 22'h000000, 22'h07C000};
    vecs[3].exp0 = 22'h000000; vecs[3].exp1 = 22'h1F0000;
    vecs[3].stall = 2; vecs[3].lat = 21;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs",
        {busy, done, rd_en, pix_addr, wgt_addr, mac_clr, mac_en, res_valid, res_data, res_idx},
        {1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 22'd0, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_mac_clr", mac_clr, 1'b0);
    chk("rst_release_busy", busy, 1'b0);

    for (int i = 0; i < 4; i++) run(i, 1'b0);

    // start held through a layer, then accepted again in the done cycle
    run(0, 1'b1);
    run(2, 1'b0);

    // reset in FEED at k=2
    for (int k = 0; k < 4; k++) pix_mem[k] = vecs[1].pix;
    for (int k = 0; k < 8; k++) wgt_mem[k] = vecs[1].w[k/4][k%4];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (rd_en && pix_addr == 2'd2) got = 1'b1;
      else @(negedge clk);
    end
    chk("reached_k2", got, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs",
        {busy, done, rd_en, pix_addr, wgt_addr, mac_clr, mac_en, res_valid, res_data, res_idx},
        {1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 22'd0, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    chk("midrun_reset_no_done", {busy, done}, 2'b00);
    run(0, 1'b0);

    // full-size address sweep
    start2 = 1'b1;
    @(posedge clk);
    lat = 0; ew = 0; addr_err = 0; nmac = 0; nres = 0; got = 1'b0;
    while (!got && lat < 9000) begin
      @(negedge clk);
      lat++;
      start2 = 1'b0;
      if (rd_en2) begin
        if (pix_addr2 != 10'(ew % 784) || wgt_addr2 != 13'(ew)) addr_err++;
        ew++;
      end
      if (mac_en2) nmac++;
      if (res_valid2) begin
        chk("mac_en_per_neuron", 64'(nmac), 64'd784);
        nmac = 0;
        nres++;
      end
      if (done2) got = 1'b1;
    end
    chk("big_done_seen", got, 1'b1);
    chk("big_latency", 64'(lat), 64'd7881);
    chk("big_addr_errors", 64'(addr_err), 64'd0);
    chk("big_addr_span", 64'(ew), 64'd7840);
    chk("big_results", 64'(nres), 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
